// File: rtl/sha256_pkg.sv
// Shared SHA-256 control constants and the block sequencer state encoding.
// The over-15 threshold is shared with message_scheduler so both agree on the W source switch.
package sha256_pkg;

  localparam int NUM_ROUNDS       = 64;
  localparam int MSG_WORDS        = 16;
  localparam int OVER15_THRESHOLD = MSG_WORDS;
  localparam int ROUND_IDX_W      = $clog2(NUM_ROUNDS);
  localparam int MSG_ADDR_W       = $clog2(MSG_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/sha256_block_sequencer_if.sv
// Block handshake, scheduler/compression control and digest handoff between buffer, sequencer and core.
// The master side is the padder/consumer environment; the slave side is the sequencer.
interface sha256_block_sequencer_if
  import sha256_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                   blk_valid;
  logic                   blk_first;
  logic                   blk_last;
  logic                   blk_ready;
  logic                   abort;
  logic [MSG_ADDR_W-1:0]  msg_addr;
  logic                   over_15;
  logic [ROUND_IDX_W-1:0] round_idx;
  logic                   round_en;
  logic                   load_work;
  logic                   use_iv;
  logic                   hash_upd;
  logic                   digest_valid;
  logic                   digest_ready;
  logic [CNT_W-1:0]       blk_cnt;

  modport master (
    output blk_valid, blk_first, blk_last, abort, digest_ready,
    input  blk_ready, msg_addr, over_15, round_idx, round_en, load_work,
           use_iv, hash_upd, digest_valid, blk_cnt
  );

  modport slave (
    input  blk_valid, blk_first, blk_last, abort, digest_ready,
    output blk_ready, msg_addr, over_15, round_idx, round_en, load_work,
           use_iv, hash_upd, digest_valid, blk_cnt
  );

endinterface

// File: rtl/sha256_round_counter.sv
// Round index counter: wraps to zero after the last round, with terminal-count and over-15 decode.
// over_15_o is decoded from the registered index so the scheduler select never glitches.
module sha256_round_counter
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
  parameter int THRESHOLD  = OVER15_THRESHOLD,
  localparam int IDX_W     = $clog2(NUM_ROUNDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             tc_o,
  output logic             over_15_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign tc_o      = (idx_q == IDX_W'(NUM_ROUNDS - 1));
  assign over_15_o = (idx_q >= IDX_W'(THRESHOLD));
  assign idx_o     = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = tc_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Sequences one 512-bit block through load, 64 rounds and hash update, then holds the digest
// for the consumer after the last block of a message.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  sha256_block_sequencer_if.slave bus
);

  seq_state_e             state_q, state_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [ROUND_IDX_W-1:0] idx;
  logic                   tc;
  logic                   over15;
  logic                   blk_ready;
  logic                   load_work;
  logic                   use_iv;
  logic                   round_en;
  logic                   hash_upd;
  logic                   digest_valid;
  logic                   abort_busy;

  assign abort_busy = bus.abort && (state_q != ST_IDLE);

  sha256_round_counter #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .THRESHOLD (OVER15_THRESHOLD)
  ) u_round_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (abort_busy),
    .en_i     (round_en),
    .idx_o    (idx),
    .tc_o     (tc),
    .over_15_o(over15)
  );

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    blk_ready    = 1'b0;
    load_work    = 1'b0;
    use_iv       = 1'b0;
    round_en     = 1'b0;
    hash_upd     = 1'b0;
    digest_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        blk_ready = 1'b1;
        // An abort arriving with the block suppresses the accept.
        if (bus.blk_valid && !bus.abort) begin
          first_d = bus.blk_first;
          last_d  = bus.blk_last;
          if (bus.blk_first) begin
            cnt_d = '0;
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_work = 1'b1;
        use_iv    = first_q;
        state_d   = ST_ROUND;
      end
      ST_ROUND: begin
        round_en = 1'b1;
        if (tc) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        hash_upd = 1'b1;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        state_d  = last_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        digest_valid = 1'b1;
        if (bus.digest_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards the whole message, including a pending hash update.
    if (abort_busy) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      hash_upd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.blk_ready    = blk_ready;
  assign bus.load_work    = load_work;
  assign bus.use_iv       = use_iv;
  assign bus.round_en     = round_en;
  assign bus.hash_upd     = hash_upd;
  assign bus.digest_valid = digest_valid;
  assign bus.blk_cnt      = cnt_q;
  assign bus.round_idx    = idx;
  assign bus.over_15      = over15;
  assign bus.msg_addr     = over15 ? MSG_ADDR_W'(MSG_WORDS - 1) : idx[MSG_ADDR_W-1:0];

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Randomized scoreboard bench for sha256_block_sequencer: stimulus predicts load/update events
// from the block timing rules, a negedge monitor checks them as the DUT presents them.
module tb_sha256_block_sequencer;
  import sha256_pkg::*;

  localparam int CNT_W = 16;

  typedef struct {
    bit isUpd;
    int cycle;
    bit useIv;
    int cnt;
    bit last;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  expT  expQ[$];
  int   modelCnt = 0;
  int   roundsSeen = 0;
  int   loadCyc = 0;
  bit   pendOn = 1'b0;
  int   pendCnt = 0;
  bit   pendLast = 1'b0;

  sha256_block_sequencer_if #(.CNT_W(CNT_W)) bus ();

  sha256_block_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops predicted events as the DUT strobes them and checks per-round decode.
  always @(negedge clk) begin : monitor
    expT e;
    int  k;
    if (!rst) begin
      checkOutput("strobe_excl",
                  32'(int'(bus.load_work) + int'(bus.round_en) + int'(bus.hash_upd) <= 1), 32'd1);
      if (pendOn) begin
        pendOn = 1'b0;
        checkOutput("post_upd_blk_cnt", 32'(bus.blk_cnt), 32'(pendCnt));
        checkOutput("post_upd_digest_valid", 32'(bus.digest_valid), 32'(pendLast));
        checkOutput("post_upd_blk_ready", 32'(bus.blk_ready), 32'(!pendLast));
      end
      if (bus.load_work) begin
        if (expQ.size() == 0 || expQ[0].isUpd) begin
          checkOutput("unexpected_load", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("load_cycle", 32'(cyc), 32'(e.cycle));
          checkOutput("load_use_iv", 32'(bus.use_iv), 32'(e.useIv));
          loadCyc    = cyc;
          roundsSeen = 0;
        end
      end
      if (bus.round_en) begin
        k = roundsSeen;
        checkOutput("round_idx", 32'(bus.round_idx), 32'(k));
        checkOutput("round_cycle", 32'(cyc), 32'(loadCyc + 1 + k));
        checkOutput("msg_addr", 32'(bus.msg_addr), 32'((k < MSG_WORDS) ? k : MSG_WORDS - 1));
        checkOutput("over_15", 32'(bus.over_15), 32'(k >= MSG_WORDS));
        roundsSeen++;
      end
      if (bus.hash_upd) begin
        if (expQ.size() == 0 || !expQ[0].isUpd) begin
          checkOutput("unexpected_hash_upd", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("upd_cycle", 32'(cyc), 32'(e.cycle));
          checkOutput("rounds_per_block", 32'(roundsSeen), 32'(NUM_ROUNDS));
          pendOn   = 1'b1;
          pendCnt  = e.cnt;
          pendLast = e.last;
        end
      end
    end
  end

  // Drives one block for a single cycle and predicts its load and update events.
  task automatic applyStimulus(input bit first, input bit last);
    expT e;
    int  n;
    n = cyc;
    if (first) modelCnt = 0;
    modelCnt = (modelCnt == (1 << CNT_W) - 1) ? modelCnt : modelCnt + 1;
    e.isUpd = 1'b0; e.cycle = n + 1; e.useIv = first; e.cnt = 0; e.last = 1'b0;
    expQ.push_back(e);
    e.isUpd = 1'b1; e.cycle = n + 2 + NUM_ROUNDS; e.useIv = 1'b0; e.cnt = modelCnt; e.last = last;
    expQ.push_back(e);
    bus.blk_valid = 1'b1;
    bus.blk_first = first;
    bus.blk_last  = last;
    step();
    bus.blk_valid = 1'b0;
    bus.blk_first = 1'($urandom);
    bus.blk_last  = 1'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!bus.blk_ready && n < 200) begin
      step();
      n++;
    end
    checkOutput("wait_ready_timeout", 32'(bus.blk_ready), 32'd1);
  endtask

  task automatic runMessage(input int nBlk, input int abortIdx, input int readyDelay);
    int n;
    bit last;
    for (int b = 0; b < nBlk; b++) begin
      waitIdle();
      last = (b == nBlk - 1);
      applyStimulus(b == 0, last);
      if (last && abortIdx >= 0) begin
        repeat (1 + abortIdx) step();
        bus.abort = 1'b1;
        expQ.delete();
        modelCnt = 0;
        step();
        bus.abort = 1'b0;
        checkOutput("abort_blk_ready", 32'(bus.blk_ready), 32'd1);
        checkOutput("abort_blk_cnt", 32'(bus.blk_cnt), 32'd0);
        checkOutput("abort_round_en", 32'(bus.round_en), 32'd0);
        return;
      end
      repeat (60) begin
        bus.blk_valid = ($urandom_range(0, 3) == 0);
        step();
      end
      bus.blk_valid = 1'b0;
    end
    n = 0;
    while (!bus.digest_valid && n < 200) begin
      step();
      n++;
    end
    checkOutput("wait_digest_timeout", 32'(bus.digest_valid), 32'd1);
    repeat (readyDelay) begin
      checkOutput("hold_digest_valid", 32'(bus.digest_valid), 32'd1);
      checkOutput("hold_blk_ready", 32'(bus.blk_ready), 32'd0);
      bus.blk_valid = 1'($urandom_range(0, 1));
      step();
    end
    bus.blk_valid    = 1'b0;
    bus.digest_ready = 1'b1;
    step();
    bus.digest_ready = 1'b0;
    checkOutput("handoff_digest_valid", 32'(bus.digest_valid), 32'd0);
    checkOutput("handoff_blk_ready", 32'(bus.blk_ready), 32'd1);
    checkOutput("handoff_blk_cnt", 32'(bus.blk_cnt), 32'(modelCnt));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_blk_ready"}, 32'(bus.blk_ready), 32'd1);
    checkOutput({tag, "_strobes"},
                32'({bus.load_work, bus.round_en, bus.hash_upd, bus.use_iv}), 32'd0);
    checkOutput({tag, "_round_idx"}, 32'(bus.round_idx), 32'd0);
    checkOutput({tag, "_msg_addr"}, 32'(bus.msg_addr), 32'd0);
    checkOutput({tag, "_over_15"}, 32'(bus.over_15), 32'd0);
    checkOutput({tag, "_blk_cnt"}, 32'(bus.blk_cnt), 32'd0);
    checkOutput({tag, "_digest_valid"}, 32'(bus.digest_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nb, ab, dl;
    rst              = 1'b1;
    bus.blk_valid    = 1'b0;
    bus.blk_first    = 1'b0;
    bus.blk_last     = 1'b0;
    bus.abort        = 1'b0;
    bus.digest_ready = 1'b0;
    repeat (3) step();
    checkResetValues("reset");
    rst = 1'b0;
    step();

    runMessage(1, -1, 0);
    runMessage(2, -1, 10);
    runMessage(1, 30, 0);
    runMessage(1, -1, 3);

    // Abort together with a block in IDLE must not start a block.
    waitIdle();
    bus.abort     = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_first = 1'b1;
    step();
    bus.abort     = 1'b0;
    bus.blk_valid = 1'b0;
    checkOutput("idle_abort_blk_ready", 32'(bus.blk_ready), 32'd1);
    checkOutput("idle_abort_load_work", 32'(bus.load_work), 32'd0);
    checkOutput("idle_abort_blk_cnt", 32'(bus.blk_cnt), 32'(modelCnt));
    step();

    for (int m = 0; m < 6; m++) begin
      nb = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_ROUNDS - 1)) : -1;
      dl = $urandom_range(0, 10);
      runMessage(nb, ab, dl);
    end

    // Synchronous reset in the middle of the rounds.
    waitIdle();
    applyStimulus(1'b1, 1'b1);
    repeat (41) step();
    checkOutput("pre_reset_round_idx", 32'(bus.round_idx), 32'd40);
    rst = 1'b1;
    expQ.delete();
    modelCnt = 0;
    step();
    checkResetValues("midreset");
    rst = 1'b0;
    step();

    runMessage(2, -1, 2);
    repeat (5) step();
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
- Controls one 512-bit block pass through the message scheduler and compression datapath.
- Accepts a block handshake and drives the scheduler's over_15 select and the padded-message word address.
- Drives the round/K-constant index, working-variable load and hash update strobes, then hands off the digest on the last block.
- Sits between the padded-message buffer/padder and message_scheduler plus the compression core.

Parameters:
- NUM_ROUNDS, 64, rounds per block; the index counter width is clog2(NUM_ROUNDS).
- MSG_WORDS, 16, words per block supplied from the buffer; over_15 asserts once the index reaches MSG_WORDS.
- CNT_W, 16, width of the block counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  padded block present in buffer.
- blk_first  in  1  qualifies blk_valid: first block of message, so load the IV.
- blk_last  in  1  qualifies blk_valid: final block of message.
- blk_ready  out  1  sequencer idle and can accept a block.
- abort  in  1  drop the current block/message and return to IDLE.
- msg_addr  out  4  word address into the padded-message buffer (combinational-read buffer).
- over_15  out  1  scheduler select: 1 means W comes from the sigma recurrence.
- round_idx  out  6  current round t, also the K-ROM address.
- round_en  out  1  compression core performs one round this cycle.
- load_work  out  1  load a..h from H (or the IV when use_iv=1).
- use_iv  out  1  valid with load_work.
- hash_upd  out  1  H <= H + a..h this cycle.
- digest_valid  out  1  final digest stable on H.
- digest_ready  in  1  consumer takes the digest.
- blk_cnt  out  CNT_W  blocks completed in the current message.

Behaviour:
- Reset values:
  - state = IDLE, blk_ready = 1.
  - All strobes 0, over_15 = 0, round_idx = 0, msg_addr = 0, blk_cnt = 0, digest_valid = 0.
- FSM states: IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE:
  - blk_ready = 1.
  - On blk_valid: capture blk_first and blk_last into registers, go to LOAD.
  - If blk_first, clear blk_cnt.
- LOAD (1 cycle): load_work = 1, use_iv = captured first flag, round_idx = 0, go to ROUND.
- ROUND (NUM_ROUNDS cycles):
  - round_en = 1.
  - round_idx counts 0..63, one step per cycle.
  - msg_addr = round_idx[3:0] while round_idx < 16; it holds 15 afterwards (don't-care).
  - over_15 = (round_idx >= 16), decoded from the registered index so it is glitch-free.
  - At round_idx = 63, go to UPDATE and reset the index to 0.
- UPDATE (1 cycle):
  - hash_upd = 1; blk_cnt increments and saturates at all-ones.
  - If the captured last flag is set, go to DONE; otherwise go to IDLE.
- DONE:
  - digest_valid = 1 and blk_ready = 0.
  - Stays in DONE until digest_ready; on the digest_ready cycle, go to IDLE.
  - digest_valid drops the cycle after.
- Latency:
  - Accept at cycle N: LOAD at N+1, rounds at N+2..N+65, hash_upd at N+66.
  - Non-last block: blk_ready returns at N+67.
  - Last block: digest_valid from N+67.
- Abort:
  - Takes effect in any state except IDLE: next state is IDLE.
  - No hash_upd issued; blk_cnt cleared; digest_valid dropped.
  - Abort in the same cycle as an IDLE accept: abort wins, no accept.
- blk_valid while not in IDLE is ignored; blk_first/blk_last are sampled only at accept.
- rst mid-operation: immediate return to reset values at the next edge; no partial strobes.
- Only one of load_work, round_en, hash_upd is high in any cycle.

Decomposition:
- Shared package sha256_pkg:
  - state enum.
  - NUM_ROUNDS and MSG_WORDS constants.
  - The over-15 threshold constant, shared with message_scheduler.
- One natural sub-module: sha256_round_counter (6-bit counter with clear/enable, terminal-count flag and over_15 decode).

Test Plan:
- Single-block message (first = last = 1):
  - Accept at cycle 0 → load_work with use_iv = 1 at cycle 1.
  - round_en at cycles 2..65; msg_addr 0..15 at cycles 2..17.
  - over_15 rises at cycle 18 (round_idx = 16).
  - hash_upd at cycle 66; digest_valid at cycle 67; blk_cnt = 1.
- Two-block message (first = 1 then last = 1):
  - Block 1: use_iv = 1, back to IDLE with blk_ready = 1 at cycle 67.
  - Block 2 accepted at cycle 67: use_iv = 0, digest_valid at cycle 134, blk_cnt = 2.
- digest_ready held low for 10 cycles:
  - digest_valid stays 1, blk_ready stays 0, blk_valid pulses are ignored.
  - digest_ready = 1 → IDLE next cycle.
- Abort asserted at round_idx = 30 → IDLE the next cycle, no hash_upd ever, blk_cnt = 0, then a fresh block runs normally.
- rst asserted at round_idx = 40 → all outputs at reset values next edge; abort + blk_valid together in IDLE → no accept.
- Coverage checks:
  - Strobes are mutually exclusive throughout.
  - Per block: exactly 64 round_en cycles and exactly one hash_upd.
